// File: rtl/tlb_inv_sequencer.sv
// rtl/tlb_inv_sequencer.sv - INVTLB sequencer: scans TLB entries and clears E on FlushOp matches
// Optional fast clear-all for ops 0/1 when TLB_INV_FASTCLR_EN is defined.
module tlb_inv_sequencer #(
    parameter int TLBNUM     = 16,
    parameter int TLBNUMSIZE = $clog2(TLBNUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [9:0]            req_asid,
    input  logic [31:0]           req_va,
    input  logic                  port_stall,
    output logic                  tlb_rd_en,
    output logic [TLBNUMSIZE-1:0] tlb_rd_idx,
    input  logic [36:0]           tlb_rd_ci,
    output logic                  tlb_clr_en,
    output logic [TLBNUMSIZE-1:0] tlb_clr_idx,
    output logic                  done,
    output logic                  op_err
`ifdef TLB_INV_FASTCLR_EN
    ,
    output logic                  tlb_clr_all
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [9:0]            asid_q, asid_d;
    logic [18:0]           vppn_q, vppn_d;
    logic [TLBNUMSIZE-1:0] cnt_q, cnt_d;
    logic                  ev_valid_q, ev_valid_d;
    logic [TLBNUMSIZE-1:0] ev_idx_q, ev_idx_d;

    // CompareItem layout: {E, ASID[9:0], G, PS[5:0], VPPN[18:0]}
    logic        ci_e;
    logic [9:0]  ci_asid;
    logic        ci_g;
    logic [5:0]  ci_ps;
    logic [18:0] ci_vppn;
    logic        va_match;
    logic        asid_match;
    logic        op_cond;
    logic        match;

    assign ci_e    = tlb_rd_ci[36];
    assign ci_asid = tlb_rd_ci[35:26];
    assign ci_g    = tlb_rd_ci[25];
    assign ci_ps   = tlb_rd_ci[24:19];
    assign ci_vppn = tlb_rd_ci[18:0];

    always_comb begin
        va_match   = 1'b0;
        asid_match = (ci_asid == asid_q);
        op_cond    = 1'b0;
        // 2MB pages only compare the VPPN bits above the page offset
        if (ci_ps == 6'd21) begin
            va_match = (ci_vppn[18:9] == vppn_q[18:9]);
        end else begin
            va_match = (ci_vppn == vppn_q);
        end
        case (op_q)
            3'd0, 3'd1: op_cond = 1'b1;
            3'd2:       op_cond = ci_g;
            3'd3:       op_cond = !ci_g;
            3'd4:       op_cond = !ci_g && asid_match;
            3'd5:       op_cond = !ci_g && asid_match && va_match;
            3'd6:       op_cond = (ci_g || asid_match) && va_match;
            default:    op_cond = 1'b0;
        endcase
        match       = ev_valid_q && ci_e && op_cond;
        tlb_clr_en  = match;
        tlb_clr_idx = match ? ev_idx_q : '0;
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        asid_d     = asid_q;
        vppn_d     = vppn_q;
        cnt_d      = cnt_q;
        ev_valid_d = 1'b0;
        ev_idx_d   = ev_idx_q;
        req_ready  = 1'b0;
        tlb_rd_en  = 1'b0;
        tlb_rd_idx = '0;
        done       = 1'b0;
        op_err     = 1'b0;
`ifdef TLB_INV_FASTCLR_EN
        tlb_clr_all = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d   = req_op;
                    asid_d = req_asid;
                    vppn_d = req_va[31:13];
                    cnt_d  = '0;
                    if (req_op == 3'd7) begin
                        state_d = FIN;
`ifdef TLB_INV_FASTCLR_EN
                    end else if (req_op <= 3'd1) begin
                        state_d = FIN;
`endif
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (!port_stall) begin
                    tlb_rd_en  = 1'b1;
                    tlb_rd_idx = cnt_q;
                    cnt_d      = cnt_q + 1'b1;
                    ev_valid_d = 1'b1;
                    ev_idx_d   = cnt_q;
                    if (cnt_q == TLBNUMSIZE'(TLBNUM - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = FIN;
            end
            FIN: begin
                done    = 1'b1;
                op_err  = (op_q == 3'd7);
`ifdef TLB_INV_FASTCLR_EN
                tlb_clr_all = (op_q <= 3'd1);
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= 3'd0;
            asid_q     <= 10'd0;
            vppn_q     <= 19'd0;
            cnt_q      <= '0;
            ev_valid_q <= 1'b0;
            ev_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            asid_q     <= asid_d;
            vppn_q     <= vppn_d;
            cnt_q      <= cnt_d;
            ev_valid_q <= ev_valid_d;
            ev_idx_q   <= ev_idx_d;
        end
    end

endmodule

// File: tb/tb_tlb_inv_sequencer.sv
// tb/tb_tlb_inv_sequencer.sv - directed self-checking bench for tlb_inv_sequencer
module tb_tlb_inv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [9:0]  req_asid;
    logic [31:0] req_va;
    logic        port_stall;
    logic        tlb_rd_en;
    logic [3:0]  tlb_rd_idx;
    logic [36:0] tlb_rd_ci;
    logic        tlb_clr_en;
    logic [3:0]  tlb_clr_idx;
    logic        done;
    logic        op_err;
`ifdef TLB_INV_FASTCLR_EN
    logic        tlb_clr_all;
`endif

    always #5 clk = ~clk;

    tlb_inv_sequencer #(.TLBNUM(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_asid    (req_asid),
        .req_va      (req_va),
        .port_stall  (port_stall),
        .tlb_rd_en   (tlb_rd_en),
        .tlb_rd_idx  (tlb_rd_idx),
        .tlb_rd_ci   (tlb_rd_ci),
        .tlb_clr_en  (tlb_clr_en),
        .tlb_clr_idx (tlb_clr_idx),
        .done        (done),
        .op_err      (op_err)
`ifdef TLB_INV_FASTCLR_EN
        ,
        .tlb_clr_all (tlb_clr_all)
`endif
    );

    // TLB model with a registered read port
    logic [36:0] mem [16];
    logic [36:0] rd_ci_q;
    always @(posedge clk) begin
        if (tlb_rd_en) rd_ci_q <= mem[tlb_rd_idx];
    end
    assign tlb_rd_ci = rd_ci_q;

    int checks = 0;
    int errors = 0;

    int          done_c;
    int          clr_cnt;
    int          rd_cnt;
    int          first_clr;
    int          last_clr;
    logic [15:0] clr_mask;
    logic        rd_ok;
    logic        err_seen;
    logic        all_seen;
    int          bad_clr;
    int          bad_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [36:0] mk(input logic e, input logic [9:0] asid, input logic g,
                                       input logic [5:0] ps, input logic [18:0] vppn);
        return {e, asid, g, ps, vppn};
    endfunction

    task automatic fill(input logic [36:0] v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [9:0] asid, input logic [31:0] va,
                          input int st0, input int stn);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = op;
        req_asid  = asid;
        req_va    = va;
        @(posedge clk); #1;
        req_valid = 1'b0;
        done_c    = -1;
        clr_cnt   = 0;
        rd_cnt    = 0;
        first_clr = -1;
        last_clr  = -1;
        clr_mask  = 16'h0;
        rd_ok     = 1'b1;
        err_seen  = 1'b0;
        all_seen  = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            port_stall = (c >= st0) && (c < st0 + stn);
            #1;
            if (tlb_rd_en) begin
                if (tlb_rd_idx != rd_cnt[3:0]) rd_ok = 1'b0;
                rd_cnt++;
            end
            if (tlb_clr_en) begin
                if (first_clr < 0) first_clr = c;
                last_clr = c;
                clr_cnt++;
                clr_mask[tlb_clr_idx] = 1'b1;
            end
            if (done) begin
                done_c   = c;
                err_seen = op_err;
`ifdef TLB_INV_FASTCLR_EN
                all_seen = tlb_clr_all;
`endif
                break;
            end
            @(posedge clk); #1;
        end
        port_stall = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 3'd0;
        req_asid   = 10'd0;
        req_va     = 32'd0;
        port_stall = 1'b0;
        fill(37'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rd_en", tlb_rd_en, 0);
        chk("rst_rd_idx", tlb_rd_idx, 0);
        chk("rst_clr_en", tlb_clr_en, 0);
        chk("rst_clr_idx", tlb_clr_idx, 0);
        chk("rst_done", done, 0);
        chk("rst_op_err", op_err, 0);

        // op 0: every valid entry cleared
        fill(mk(1'b1, 10'h3, 1'b0, 6'd12, 19'h1));
        run_op(3'd0, 10'h0, 32'h0, 0, 0);
`ifdef TLB_INV_FASTCLR_EN
        chk("op0_done_cycle", done_c, 1);
        chk("op0_clr_cnt", clr_cnt, 0);
        chk("op0_rd_cnt", rd_cnt, 0);
        chk("op0_clr_all", all_seen, 1);
`else
        chk("op0_done_cycle", done_c, 18);
        chk("op0_clr_mask", clr_mask, 16'hFFFF);
        chk("op0_clr_cnt", clr_cnt, 16);
        chk("op0_first_clr", first_clr, 2);
        chk("op0_last_clr", last_clr, 17);
        chk("op0_rd_cnt", rd_cnt, 16);
        chk("op0_rd_seq", rd_ok, 1);
`endif
        chk("op0_op_err", err_seen, 0);

        // op 5: ASID and VA must both match on a non-global entry
        fill(37'd0);
        mem[3] = mk(1'b1, 10'h5, 1'b0, 6'd12, 19'h091A3);
        mem[7] = mk(1'b1, 10'h6, 1'b0, 6'd12, 19'h091A3);
        run_op(3'd5, 10'h5, 32'h1234_6000, 0, 0);
        chk("op5_clr_mask", clr_mask, 16'h0008);
        chk("op5_clr_cnt", clr_cnt, 1);
        chk("op5_done_cycle", done_c, 18);

        // op 6: global or ASID match, 2MB page compares VPPN[18:9]; E=0 entry never cleared
        fill(37'd0);
        mem[2]  = mk(1'b1, 10'h3FF, 1'b1, 6'd21, 19'h00200);
        mem[9]  = mk(1'b1, 10'h001, 1'b0, 6'd21, 19'h00200);
        mem[11] = mk(1'b0, 10'h002, 1'b1, 6'd21, 19'h00200);
        run_op(3'd6, 10'h002, 32'h0040_0000, 0, 0);
        chk("op6_clr_mask", clr_mask, 16'h0004);
        chk("op6_clr_cnt", clr_cnt, 1);

        // op 2 with 3 stall cycles mid-scan
        fill(mk(1'b1, 10'h0, 1'b0, 6'd12, 19'h0));
        mem[1]  = mk(1'b1, 10'h0, 1'b1, 6'd12, 19'h0);
        mem[4]  = mk(1'b1, 10'h0, 1'b1, 6'd12, 19'h0);
        mem[10] = mk(1'b1, 10'h0, 1'b1, 6'd12, 19'h0);
        mem[6]  = mk(1'b0, 10'h0, 1'b1, 6'd12, 19'h0);
        run_op(3'd2, 10'h0, 32'h0, 5, 3);
        chk("op2_done_cycle", done_c, 21);
        chk("op2_rd_seq", rd_ok, 1);
        chk("op2_rd_cnt", rd_cnt, 16);
        chk("op2_clr_mask", clr_mask, 16'h0412);
        chk("op2_clr_cnt", clr_cnt, 3);

        // op 7: invalid, no reads, done and op_err together
        run_op(3'd7, 10'h0, 32'h0, 0, 0);
        chk("op7_done_cycle", done_c, 1);
        chk("op7_op_err", err_seen, 1);
        chk("op7_rd_cnt", rd_cnt, 0);
        chk("op7_clr_cnt", clr_cnt, 0);

        // reset while scan issues index 5
        fill(mk(1'b1, 10'h0, 1'b0, 6'd12, 19'h0));
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = 3'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("abort_rd_idx", tlb_rd_idx, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("abort_clr_en", tlb_clr_en, 0);
        chk("abort_req_ready", req_ready, 1);
        chk("abort_done", done, 0);
        bad_clr  = 0;
        bad_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #2;
            if (tlb_clr_en) bad_clr++;
            if (done) bad_done++;
        end
        chk("abort_no_clr", bad_clr, 0);
        chk("abort_no_done", bad_done, 0);

        run_op(3'd3, 10'h0, 32'h0, 0, 0);
        chk("op3_done_cycle", done_c, 18);
        chk("op3_clr_mask", clr_mask, 16'hFFFF);
        chk("op3_rd_seq", rd_ok, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
